// File: rtl/bcd_edit_pkg.sv
// bcd_edit_pkg
// Shared definitions for the BCD field editor:
//   - field select codes
//   - editor FSM state encoding
//   - field_min / field_max: 2-digit BCD limits for each field code
//     (idle codes return 00..00)
package bcd_edit_pkg;

    localparam logic [3:0] FLD_IDLE  = 4'd0;
    localparam logic [3:0] FLD_SEC   = 4'd1;
    localparam logic [3:0] FLD_MIN   = 4'd2;
    localparam logic [3:0] FLD_HOUR  = 4'd3;
    localparam logic [3:0] FLD_DATE  = 4'd4;
    localparam logic [3:0] FLD_MONTH = 4'd5;
    localparam logic [3:0] FLD_YEAR  = 4'd6;
    localparam logic [3:0] FLD_T_HR  = 4'd7;
    localparam logic [3:0] FLD_T_MIN = 4'd8;
    localparam logic [3:0] FLD_T_SEC = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    function automatic logic field_active(input logic [3:0] fld);
        return (fld >= FLD_SEC) && (fld <= FLD_T_SEC);
    endfunction

    function automatic logic [7:0] field_min(input logic [3:0] fld);
        logic [7:0] v;
        v = 8'h00;
        if (fld == FLD_DATE || fld == FLD_MONTH) begin
            v = 8'h01;
        end
        return v;
    endfunction

    function automatic logic [7:0] field_max(input logic [3:0] fld);
        logic [7:0] v;
        case (fld)
            FLD_SEC, FLD_MIN, FLD_T_MIN, FLD_T_SEC: v = 8'h59;
            FLD_HOUR, FLD_T_HR:                     v = 8'h23;
            FLD_DATE:                               v = 8'h31;
            FLD_MONTH:                              v = 8'h12;
            FLD_YEAR:                               v = 8'h99;
            default:                                v = 8'h00;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/bcd_field_editor_stepper.sv
// bcd_stepper
// Combinational single BCD step with wrap inside [min_i, max_i].
//   value_i    current BCD value (assumed valid and in range)
//   dir_i      1 = increment, 0 = decrement
//   min_i      lower limit, max_i upper limit
//   next_o     stepped value (wraps max->min on inc, min->max on dec)
//   at_limit_o value already sits at the limit in the step direction
module bcd_stepper #(
    parameter int NUM_DIGITS = 2
) (
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic                    dir_i,
    input  logic [4*NUM_DIGITS-1:0] min_i,
    input  logic [4*NUM_DIGITS-1:0] max_i,
    output logic [4*NUM_DIGITS-1:0] next_o,
    output logic                    at_limit_o
);
    import bcd_edit_pkg::*;

    logic [4*NUM_DIGITS-1:0] w_inc;
    logic [4*NUM_DIGITS-1:0] w_dec;
    logic                    w_carry;
    logic                    w_borrow;
    logic                    w_at_max;
    logic                    w_at_min;

    // Digit-serial ripple: a digit only moves while a carry/borrow is pending.
    always_comb begin
        w_inc   = value_i;
        w_carry = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_carry) begin
                if (value_i[4*i +: 4] >= 4'd9) begin
                    w_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_inc[4*i +: 4] = value_i[4*i +: 4] + 4'd1;
                    w_carry         = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_dec    = value_i;
        w_borrow = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_borrow) begin
                if (value_i[4*i +: 4] == 4'd0) begin
                    w_dec[4*i +: 4] = 4'd9;
                end else begin
                    w_dec[4*i +: 4] = value_i[4*i +: 4] - 4'd1;
                    w_borrow        = 1'b0;
                end
            end
        end
    end

    assign w_at_max   = (value_i == max_i);
    assign w_at_min   = (value_i == min_i);
    assign at_limit_o = dir_i ? w_at_max : w_at_min;
    assign next_o     = dir_i ? (w_at_max ? min_i : w_inc)
                              : (w_at_min ? max_i : w_dec);

endmodule

// File: rtl/bcd_field_editor.sv
// bcd_field_editor
// BCD value editor for the RTC/timer setting path. A field is selected,
// then stepped with up/down buttons; a held button auto-repeats after a
// hold delay. Values wrap within per-field limits.
// Optional build macro: BCD_EDIT_SATURATE_EN -- inc at max / dec at min
// become no-ops (no step pulse) instead of wrapping.
// Ports:
//   clk_i       system clock
//   rst_i       synchronous active-high reset
//   field_i     field select (0, 10..15 idle)
//   load_i      one-cycle pulse, capture load_val_i
//   load_val_i  BCD preload value from RTC
//   inc_i/dec_i button levels (both high = released)
//   value_o     edited BCD value
//   dirty_o     stepped since last load / field change
//   step_o      one-cycle pulse per applied step
//
// state   | meaning
// IDLE    | no button held; a press steps immediately
// HOLD    | button held, counting HOLD_TICKS ticks before auto-repeat
// REPEAT  | button held, one step per tick
module bcd_field_editor
    import bcd_edit_pkg::*;
#(
    parameter int CLK_DIV    = 10000000,
    parameter int HOLD_TICKS = 3,
    parameter int NUM_DIGITS = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [3:0]              field_i,
    input  logic                    load_i,
    input  logic [4*NUM_DIGITS-1:0] load_val_i,
    input  logic                    inc_i,
    input  logic                    dec_i,
    output logic [4*NUM_DIGITS-1:0] value_o,
    output logic                    dirty_o,
    output logic                    step_o
);
    localparam int W  = 4 * NUM_DIGITS;
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_TICKS - 1);

    state_t          r_state;
    logic [PW-1:0]   r_presc;
    logic [HW-1:0]   r_hold;
    logic [W-1:0]    r_value;
    logic            r_dirty;
    logic            r_step;
    logic            r_dir;
    logic [3:0]      r_field_prev;
    logic            r_wait_rel;

    state_t          w_state_nxt;
    logic [PW-1:0]   w_presc_nxt;
    logic [HW-1:0]   w_hold_nxt;
    logic [W-1:0]    w_value_nxt;
    logic            w_dirty_nxt;
    logic            w_step_nxt;
    logic            w_dir_nxt;
    logic            w_wait_rel_nxt;

    logic [W-1:0]    w_min;
    logic [W-1:0]    w_max;
    logic [W-1:0]    w_step_val;
    logic            w_at_limit;
    logic            w_press;
    logic            w_tick;
    logic            w_field_chg;
    logic            w_field_act;
    logic            w_digits_ok;
    logic            w_load_ok;
    logic            w_step_req;
    logic            w_step_block;

    assign w_min       = W'(field_min(field_i));
    assign w_max       = W'(field_max(field_i));
    assign w_press     = inc_i ^ dec_i;
    assign w_tick      = (r_presc == PRESC_LAST);
    assign w_field_chg = (field_i != r_field_prev);
    assign w_field_act = field_active(field_i);

    always_comb begin
        w_digits_ok = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (load_val_i[4*i +: 4] > 4'd9) begin
                w_digits_ok = 1'b0;
            end
        end
    end

    assign w_load_ok = w_digits_ok && (load_val_i >= w_min) && (load_val_i <= w_max);

    bcd_stepper #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_stepper (
        .value_i    (r_value),
        .dir_i      (inc_i),
        .min_i      (w_min),
        .max_i      (w_max),
        .next_o     (w_step_val),
        .at_limit_o (w_at_limit)
    );

`ifdef BCD_EDIT_SATURATE_EN
    assign w_step_block = w_at_limit;
`else
    assign w_step_block = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_presc      <= '0;
            r_hold       <= '0;
            r_value      <= '0;
            r_dirty      <= 1'b0;
            r_step       <= 1'b0;
            r_dir        <= 1'b0;
            r_field_prev <= 4'd0;
            r_wait_rel   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_presc      <= w_presc_nxt;
            r_hold       <= w_hold_nxt;
            r_value      <= w_value_nxt;
            r_dirty      <= w_dirty_nxt;
            r_step       <= w_step_nxt;
            r_dir        <= w_dir_nxt;
            r_field_prev <= field_i;
            r_wait_rel   <= w_wait_rel_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_presc_nxt    = r_presc;
        w_hold_nxt     = r_hold;
        w_value_nxt    = r_value;
        w_dirty_nxt    = r_dirty;
        w_step_nxt     = 1'b0;
        w_dir_nxt      = r_dir;
        // A button still held across a field change must be released before
        // it can start a new edit in the new field.
        w_wait_rel_nxt = r_wait_rel & w_press;
        w_step_req     = 1'b0;

        if (w_field_chg) begin
            w_value_nxt    = w_min;
            w_dirty_nxt    = 1'b0;
            w_state_nxt    = ST_IDLE;
            w_presc_nxt    = '0;
            w_hold_nxt     = '0;
            w_wait_rel_nxt = w_press;
        end else if (!w_field_act) begin
            w_value_nxt = '0;
            w_dirty_nxt = 1'b0;
            w_state_nxt = ST_IDLE;
            w_presc_nxt = '0;
            w_hold_nxt  = '0;
        end else if (load_i) begin
            w_value_nxt = w_load_ok ? load_val_i : w_min;
            w_dirty_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_presc_nxt = '0;
                    w_hold_nxt  = '0;
                    if (w_press && !r_wait_rel) begin
                        w_step_req  = 1'b1;
                        w_dir_nxt   = inc_i;
                        w_state_nxt = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // A direction flip is treated as a release; IDLE then
                    // sees the new press on the following edge.
                    if (!w_press || (inc_i != r_dir)) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
                        if (w_tick) begin
                            if (r_hold == HOLD_LAST) begin
                                w_step_req  = 1'b1;
                                w_hold_nxt  = '0;
                                w_state_nxt = ST_REPEAT;
                            end else begin
                                w_hold_nxt = r_hold + 1'b1;
                            end
                        end
                    end
                end
                ST_REPEAT: begin
                    if (!w_press || (inc_i != r_dir)) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
                        w_step_req  = w_tick;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase

            if (w_step_req && !w_step_block) begin
                w_value_nxt = w_step_val;
                w_dirty_nxt = 1'b1;
                w_step_nxt  = 1'b1;
            end
        end
    end

    assign value_o = r_value;
    assign dirty_o = r_dirty;
    assign step_o  = r_step;

endmodule

// File: tb/tb_bcd_field_editor.sv
module tb_bcd_field_editor;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] field;
    logic       load;
    logic [7:0] load_val;
    logic       inc;
    logic       dec;
    logic [7:0] value;
    logic       dirty;
    logic       step;

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [7:0] val;
        int         cyc;
    } exp_t;

    exp_t q[$];

    bcd_field_editor #(
        .CLK_DIV    (4),
        .HOLD_TICKS (2),
        .NUM_DIGITS (2)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .field_i    (field),
        .load_i     (load),
        .load_val_i (load_val),
        .inc_i      (inc),
        .dec_i      (dec),
        .value_o    (value),
        .dirty_o    (dirty),
        .step_o     (step)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Scoreboard monitor: every step pulse must match the oldest expected step.
    always @(negedge clk) begin
        if (!rst && step) begin
            exp_t e;
            n_checks++;
            if (q.size() == 0) begin
                $display("FAIL step_unexpected value=%h cyc=%0d required no step", value, cyc);
            end else begin
                e = q.pop_front();
                if (value === e.val && dirty === 1'b1 && cyc == e.cyc) begin
                    n_pass++;
                end else begin
                    $display("FAIL step value=%h dirty=%b cyc=%0d required value=%h dirty=1 cyc=%0d",
                             value, dirty, cyc, e.val, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, req);
    endtask

    task automatic expect_step(input logic [7:0] v, input int at_cyc);
        exp_t e;
        e.val = v;
        e.cyc = at_cyc;
        q.push_back(e);
    endtask

    // One-cycle press then one released cycle so the FSM returns to IDLE.
    task automatic press(input logic up, input logic [7:0] exp_v, input bit stepped);
        if (stepped) expect_step(exp_v, cyc + 1);
        if (up) inc = 1'b1;
        else    dec = 1'b1;
        @(negedge clk);
        inc = 1'b0;
        dec = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_load(input logic [7:0] v);
        load_val = v;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic set_field(input logic [3:0] f);
        field = f;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst = 1'b1; field = 4'd0; load = 1'b0; load_val = 8'h00; inc = 1'b0; dec = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_value", value, 8'h00);
        check("reset_dirty", {7'd0, dirty}, 8'h00);
        check("reset_step",  {7'd0, step},  8'h00);

        // sec: single press 00 -> 01
        set_field(4'd1);
        check("sec_min", value, 8'h00);
        press(1'b1, 8'h01, 1'b1);
        check("sec_after", value, 8'h01);
        check("sec_dirty", {7'd0, dirty}, 8'h01);

        // hour: load 22, two presses -> 23 -> 00
        set_field(4'd3);
        check("hour_fieldchg_value", value, 8'h00);
        check("hour_fieldchg_dirty", {7'd0, dirty}, 8'h00);
        do_load(8'h22);
        check("hour_load", value, 8'h22);
        check("hour_load_dirty", {7'd0, dirty}, 8'h00);
        press(1'b1, 8'h23, 1'b1);
        press(1'b1, 8'h00, 1'b1);
        check("hour_wrap", value, 8'h00);
        check("hour_dirty", {7'd0, dirty}, 8'h01);

        // date: dec held 20 cycles, hold delay then auto-repeat
        set_field(4'd4);
        check("date_min", value, 8'h01);
        c = cyc;
        expect_step(8'h31, c + 1);
        expect_step(8'h30, c + 9);
        expect_step(8'h29, c + 13);
        expect_step(8'h28, c + 17);
        dec = 1'b1;
        repeat (20) @(negedge clk);
        dec = 1'b0;
        repeat (6) @(negedge clk);
        check("date_hold_end", value, 8'h28);

        // month: invalid loads fall back to min, valid load accepted
        set_field(4'd5);
        do_load(8'h13);
        check("month_load_13", value, 8'h01);
        check("month_load_dirty", {7'd0, dirty}, 8'h00);
        do_load(8'h1A);
        check("month_load_1A", value, 8'h01);
        do_load(8'h12);
        check("month_load_12", value, 8'h12);
        press(1'b1, 8'h01, 1'b1);
        check("month_wrap", value, 8'h01);

        // min: field change mid-repeat discards edit, held button ignored
        set_field(4'd2);
        c = cyc;
        expect_step(8'h01, c + 1);
        expect_step(8'h02, c + 9);
        expect_step(8'h03, c + 13);
        inc = 1'b1;
        repeat (14) @(negedge clk);
        field = 4'd1;
        @(negedge clk);
        check("midrep_value", value, 8'h00);
        check("midrep_dirty", {7'd0, dirty}, 8'h00);
        repeat (8) @(negedge clk);
        check("midrep_held_nostep", value, 8'h00);
        inc = 1'b0;
        @(negedge clk);
        press(1'b1, 8'h01, 1'b1);
        check("midrep_newpress", value, 8'h01);

        // idle field ignores buttons and load
        set_field(4'd12);
        check("idle_value", value, 8'h00);
        do_load(8'h05);
        press(1'b1, 8'h00, 1'b0);
        check("idle_ignore", value, 8'h00);

        // year: limit behaviour
        set_field(4'd6);
        do_load(8'h99);
`ifdef BCD_EDIT_SATURATE_EN
        press(1'b1, 8'h99, 1'b0);
        check("year_sat_max", value, 8'h99);
        do_load(8'h00);
        press(1'b0, 8'h00, 1'b0);
        check("year_sat_min", value, 8'h00);
`else
        press(1'b1, 8'h00, 1'b1);
        check("year_wrap_max", value, 8'h00);
        press(1'b0, 8'h99, 1'b1);
        check("year_wrap_min", value, 8'h99);
        press(1'b0, 8'h98, 1'b1);
        check("year_dec_units", value, 8'h98);
`endif

        // both buttons high counts as released
        inc = 1'b1; dec = 1'b1;
        repeat (3) @(negedge clk);
        inc = 1'b0; dec = 1'b0;
        @(negedge clk);
`ifdef BCD_EDIT_SATURATE_EN
        check("both_released", value, 8'h00);
`else
        check("both_released", value, 8'h98);
`endif

        // reset mid-hold aborts with no step
        set_field(4'd8);
        expect_step(8'h01, cyc + 1);
        inc = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        inc = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_midhold_value", value, 8'h00);
        check("rst_midhold_dirty", {7'd0, dirty}, 8'h00);

        repeat (4) @(negedge clk);
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL missing_steps actual=%0d required=0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
